// File: rtl/ls_ahb_arb_2to1.sv
// rtl/ls_ahb_arb_2to1.sv - two-master to one-slave AHB arbiter for the low-speed bus
// Losing masters park their address in a one-entry buffer; grant is held across bursts.
module ls_ahb_arb_2to1 #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RR_EN  = 1
) (
    input  logic              pmu_lsbus_hclk,
    input  logic              pmu_lsbus_hrst,
    input  logic              m0_hsel,
    input  logic [1:0]        m0_htrans,
    input  logic [ADDR_W-1:0] m0_haddr,
    input  logic              m0_hwrite,
    input  logic [2:0]        m0_hsize,
    input  logic [2:0]        m0_hburst,
    input  logic [3:0]        m0_hprot,
    input  logic [DATA_W-1:0] m0_hwdata,
    output logic [DATA_W-1:0] m0_hrdata,
    output logic              m0_hready,
    output logic [1:0]        m0_hresp,
    input  logic              m1_hsel,
    input  logic [1:0]        m1_htrans,
    input  logic [ADDR_W-1:0] m1_haddr,
    input  logic              m1_hwrite,
    input  logic [2:0]        m1_hsize,
    input  logic [2:0]        m1_hburst,
    input  logic [3:0]        m1_hprot,
    input  logic [DATA_W-1:0] m1_hwdata,
    output logic [DATA_W-1:0] m1_hrdata,
    output logic              m1_hready,
    output logic [1:0]        m1_hresp,
    output logic              s_hsel,
    output logic [1:0]        s_htrans,
    output logic [ADDR_W-1:0] s_haddr,
    output logic              s_hwrite,
    output logic [2:0]        s_hsize,
    output logic [2:0]        s_hburst,
    output logic [3:0]        s_hprot,
    output logic [DATA_W-1:0] s_hwdata,
    input  logic [DATA_W-1:0] s_hrdata,
    input  logic              s_hready,
    input  logic [1:0]        s_hresp
);

    localparam logic [1:0] TR_IDLE    = 2'b00;
    localparam logic [1:0] TR_NONSEQ  = 2'b10;
    localparam logic [1:0] TR_SEQ     = 2'b11;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;
    localparam logic [2:0] HB_INCR    = 3'b001;

    logic              sel, dvld, down, last, ilock;
    logic [3:0]        bcnt;
    logic              pend0_vld, pend1_vld;
    logic [ADDR_W-1:0] pend0_haddr, pend1_haddr;
    logic              pend0_hwrite, pend1_hwrite;
    logic [2:0]        pend0_hsize, pend1_hsize, pend0_hburst, pend1_hburst;
    logic [3:0]        pend0_hprot, pend1_hprot;
    logic [1:0]        pend0_htrans, pend1_htrans;

    logic              live0, live1, req0, req1, req_sel, pend_sel;
    logic [1:0]        src_htrans;
    logic [ADDR_W-1:0] src_haddr;
    logic              src_hwrite;
    logic [2:0]        src_hsize, src_hburst;
    logic [3:0]        src_hprot;
    logic [3:0]        bcnt_next;
    logic              ilock_next, lock_next, last_next, sel_next;

    assign live0    = m0_hsel & m0_htrans[1];
    assign live1    = m1_hsel & m1_htrans[1];
    assign req0     = pend0_vld | live0;
    assign req1     = pend1_vld | live1;
    assign req_sel  = sel ? req1 : req0;
    assign pend_sel = sel ? pend1_vld : pend0_vld;

    // A buffered address always goes out before the owner's live one.
    always_comb begin
        src_htrans = m0_htrans;
        src_haddr  = m0_haddr;
        src_hwrite = m0_hwrite;
        src_hsize  = m0_hsize;
        src_hburst = m0_hburst;
        src_hprot  = m0_hprot;
        if (pend_sel && sel) begin
            src_htrans = pend1_htrans;
            src_haddr  = pend1_haddr;
            src_hwrite = pend1_hwrite;
            src_hsize  = pend1_hsize;
            src_hburst = pend1_hburst;
            src_hprot  = pend1_hprot;
        end else if (pend_sel) begin
            src_htrans = pend0_htrans;
            src_haddr  = pend0_haddr;
            src_hwrite = pend0_hwrite;
            src_hsize  = pend0_hsize;
            src_hburst = pend0_hburst;
            src_hprot  = pend0_hprot;
        end else if (sel) begin
            src_htrans = m1_htrans;
            src_haddr  = m1_haddr;
            src_hwrite = m1_hwrite;
            src_hsize  = m1_hsize;
            src_hburst = m1_hburst;
            src_hprot  = m1_hprot;
        end
    end

    assign s_hsel    = req_sel;
    assign s_htrans  = req_sel ? src_htrans : TR_IDLE;
    assign s_haddr   = src_haddr;
    assign s_hwrite  = src_hwrite;
    assign s_hsize   = src_hsize;
    assign s_hburst  = src_hburst;
    assign s_hprot   = src_hprot;
    assign s_hwdata  = down ? m1_hwdata : m0_hwdata;
    assign m0_hrdata = s_hrdata;
    assign m1_hrdata = s_hrdata;
    assign m0_hresp  = (dvld && !down) ? s_hresp : RESP_OKAY;
    assign m1_hresp  = (dvld && down) ? s_hresp : RESP_OKAY;

    always_comb begin
        m0_hready = 1'b1;
        if (dvld && !down)  m0_hready = s_hready;
        else if (pend0_vld) m0_hready = 1'b0;
        else if (!sel)      m0_hready = s_hready;
        m1_hready = 1'b1;
        if (dvld && down)   m1_hready = s_hready;
        else if (pend1_vld) m1_hready = 1'b0;
        else if (sel)       m1_hready = s_hready;
    end

    always_comb begin
        bcnt_next  = bcnt;
        ilock_next = ilock;
        last_next  = last;
        sel_next   = sel;
        if (!s_hready) begin
            // First ERROR cycle drops the burst lock so the other master can win.
            if (s_hresp == RESP_ERROR) begin
                bcnt_next  = 4'd0;
                ilock_next = 1'b0;
            end
        end else if (req_sel) begin
            ilock_next = (src_hburst == HB_INCR);
            if (src_htrans == TR_NONSEQ) begin
                last_next = sel;
                case (src_hburst)
                    3'b010, 3'b011: bcnt_next = 4'd3;
                    3'b100, 3'b101: bcnt_next = 4'd7;
                    3'b110, 3'b111: bcnt_next = 4'd15;
                    default:        bcnt_next = 4'd0;
                endcase
            end else if (src_htrans == TR_SEQ && bcnt != 4'd0) begin
                bcnt_next = bcnt - 4'd1;
            end
        end else begin
            ilock_next = 1'b0;
        end
        lock_next = (bcnt_next != 4'd0) | ilock_next;
        if (s_hready && !lock_next) begin
            if (req0 && req1) sel_next = (RR_EN != 0) ? ~last_next : 1'b0;
            else if (req0)    sel_next = 1'b0;
            else if (req1)    sel_next = 1'b1;
        end
    end

    always_ff @(posedge pmu_lsbus_hclk) begin
        if (pmu_lsbus_hrst) begin
            sel       <= 1'b0;
            dvld      <= 1'b0;
            down      <= 1'b0;
            last      <= 1'b1;
            bcnt      <= 4'd0;
            ilock     <= 1'b0;
            pend0_vld <= 1'b0;
            pend1_vld <= 1'b0;
        end else begin
            sel   <= sel_next;
            last  <= last_next;
            bcnt  <= bcnt_next;
            ilock <= ilock_next;
            if (s_hready) begin
                dvld <= req_sel;
                down <= sel;
            end
            if (live0 && sel && m0_hready) begin
                pend0_vld    <= 1'b1;
                pend0_htrans <= m0_htrans;
                pend0_haddr  <= m0_haddr;
                pend0_hwrite <= m0_hwrite;
                pend0_hsize  <= m0_hsize;
                pend0_hburst <= m0_hburst;
                pend0_hprot  <= m0_hprot;
            end else if (!sel && s_hready) begin
                pend0_vld <= 1'b0;
            end
            if (live1 && !sel && m1_hready) begin
                pend1_vld    <= 1'b1;
                pend1_htrans <= m1_htrans;
                pend1_haddr  <= m1_haddr;
                pend1_hwrite <= m1_hwrite;
                pend1_hsize  <= m1_hsize;
                pend1_hburst <= m1_hburst;
                pend1_hprot  <= m1_hprot;
            end else if (sel && s_hready) begin
                pend1_vld <= 1'b0;
            end
        end
    end

endmodule

// File: doc/ls_ahb_arb_2to1.md
Name: ls_ahb_arb_2to1

Overview:
Two-master to one-slave AHB arbiter that shares the low-speed bus master port (the hmain0 → lsbus slave port) between two requesters, e.g. the CPU path and a DMA path.
- Each master owns a one-entry pending-address buffer, so a master that loses arbitration still completes AHB handshakes legally.
- Arbitration is round-robin by default. Grant never changes inside a fixed-length or INCR burst.
- Sits directly in front of the 1-to-6 low-speed matrix and runs on the lsbus clock.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
RR_EN, 1, 1 = round-robin; 0 = fixed priority, m0 wins

Ports:
pmu_lsbus_hclk  in  1  bus clock
pmu_lsbus_hrst  in  1  reset, synchronous, active-high
mN_hsel/htrans/haddr/hwrite/hsize/hburst/hprot/hwdata  in  1/2/ADDR_W/1/3/3/4/DATA_W  master N (N=0,1) address/data-phase signals
mN_hrdata  out  DATA_W  read data to master N
mN_hready  out  1  ready to master N
mN_hresp  out  2  response to master N
s_hsel/htrans/haddr/hwrite/hsize/hburst/hprot  out  1/2/ADDR_W/1/3/3/4  address phase to the slave port
s_hwdata  out  DATA_W  write data to the slave port
s_hrdata/s_hready/s_hresp  in  DATA_W/1/2  slave port response

Behaviour:
- Interface: one clock, pmu_lsbus_hclk. Reset pmu_lsbus_hrst is synchronous and active-high.
- Registered state:
  - sel: address-phase owner, reset 0.
  - dvld / down: data-phase valid and data-phase owner, reset 0/0.
  - pendN_vld, reset 0, plus pendN_{haddr,hwrite,hsize,hburst,hprot,htrans}.
  - bcnt: remaining beats, 4 bits, reset 0.
  - ilock: INCR lock, reset 0.
  - last: last granted master, reset 1, so m0 wins first.
- Request definitions:
  - liveN = mN_hsel & mN_htrans[1].
  - reqN = pendN_vld | liveN.
- Slave address mux: source is the pend registers if pend[sel]_vld, else master sel's live signals.
  - s_hsel = req[sel].
  - s_htrans = source htrans if req[sel], else IDLE.
  - Reset/idle outputs: s_htrans = 00, s_hsel = 0.
- Data-phase tracking: s_hwdata = m[down]_hwdata. On each edge with s_hready=1: dvld <= req[sel], down <= sel.
- mN_hready, first matching rule wins:
  1. dvld & down==N → s_hready.
  2. pendN_vld → 0.
  3. sel==N → s_hready.
  4. Otherwise → 1.
- mN_hresp = (dvld & down==N) ? s_hresp : OKAY.
- mN_hrdata = s_hrdata (broadcast).
- Pend capture: liveN & sel!=N & mN_hready=1 at an edge → pendN_* <= live signals, pendN_vld <= 1.
- Pend release: pendN_vld clears on the edge where sel==N & s_hready=1, i.e. the buffered address is accepted. The master then sees rule 1 for its data phase.
- Burst tracking, on accepted address (s_hready & req[sel]):
  - NONSEQ with INCR4/WRAP4, INCR8/WRAP8, INCR16/WRAP16 → bcnt <= 3/7/15.
  - SEQ → bcnt <= bcnt-1.
  - BUSY → no change.
  - ilock <= (hburst==INCR & htrans!=IDLE).
  - When s_hready=1 with no request on sel → ilock <= 0.
- lock_next = (bcnt_next!=0) | ilock_next.
- Arbitration, on edge with s_hready=1 and !lock_next:
  - Only one reqN → sel <= N.
  - Both request → sel <= (RR_EN ? ~last : 0).
  - No request → sel holds.
  - last <= sel whenever a NONSEQ is accepted.
- Switch latency: 0 idle cycles when the new owner has a pend entry or live request.
- ERROR: s_hresp=ERROR in the first cycle (s_hready=0) clears bcnt and ilock next edge, so the erroring master may abort its burst and the other master can be granted.
- Simultaneous capture and release for the same master cannot occur, because rule 2 blocks capture while pendN_vld=1.
- Reset mid-operation: all state returns to reset values next edge and pend entries are discarded. External masters are reset by the same reset.

Test Plan:
- m0-only SINGLE read of 0x4000_0010; slave inserts 2 waits → m0_hready low for exactly 2 cycles, m0_hrdata = s_hrdata, m1_hready=1 throughout.
- Both NONSEQ SINGLE writes in the same cycle after reset → m0 issued first, m1 captured to pend (m1_hready=1, then 0). Next cycle s_haddr = m1 address, taken from the pend entry. m1_hready returns high when its data phase completes. s_hwdata matches each owner's data.
- m0 INCR4 from 0x100; m1 requests during beat 2 → s_haddr sequence 0x100/104/108/10C, then m1 address; no interleave.
- Both issue back-to-back SINGLE reads continuously with RR_EN=1 → grants alternate 0,1,0,1. With RR_EN=0 → m0 only, m1 starved while m0 requests.
- Slave returns 2-cycle ERROR on m1's pended transfer → m1_hresp=ERROR both cycles, m0_hresp=OKAY, bcnt=0 afterwards.
- Assert pmu_lsbus_hrst while pend1_vld=1 → next cycle pend1_vld=0, sel=0, s_htrans=IDLE, both mN_hready=1.
